pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised pipeline stage register with a valid/ready handshake, a two-entry skid buffer, external stall, synchronous flush and a saturating hold-cycle counter. It replaces the fixed-width, stall/flush-only inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one reusable block. Any stage boundary can now apply back-pressure without losing data, and each boundary reports how long it has been held.

## Interface
Parameters:
- DATA_WIDTH, 64, payload width in bits (e.g. PC[63:32] + instruction[31:0] for IF/ID).
- FLUSH_VALUE, 0, value of OutData after reset or flush.
- COUNT_WIDTH, 16, width of HoldCount.

Ports:
- Clk  input  1  clock; all state updates on its rising edge.
- Reset_n  input  1  reset; asynchronous, active-low.
- InValid  input  1  upstream has a word on InData.
- InReady  output  1  stage accepts a word this cycle; registered, equal to !skid_valid.
- InData  input  DATA_WIDTH  upstream payload.
- OutValid  output  1  OutData holds a valid word; registered.
- OutReady  input  1  downstream accepts the word.
- OutData  output  DATA_WIDTH  payload from the main register; registered.
- Stall  input  1  hold request from hazard logic; 1 blocks the output transfer.
- Flush  input  1  discard all contents (branch/jump redirect).
- HoldCount  output  COUNT_WIDTH  saturating count of cycles with OutValid=1 and no output transfer.

## Operation
- Storage: a main register (main_valid, main_data) drives OutValid and OutData. A skid register (skid_valid, skid_data) is internal.
- in_xfer = InValid & InReady. out_xfer = OutValid & OutReady & !Stall.
- Flush has the highest priority. On the next edge main_valid=0, skid_valid=0 and main_data=FLUSH_VALUE. The input word on that cycle is dropped even if in_xfer=1.
- If Flush=0, the next state follows from main and skid occupancy:
  - Main empty, skid empty: on in_xfer, InData is loaded into main.
  - Main full, skid empty, out_xfer=1: on in_xfer, InData is loaded into main; otherwise main_valid=0 and main_data holds its last value.
  - Main full, skid empty, out_xfer=0: on in_xfer, InData is loaded into skid and skid_valid=1.
  - Main full, skid full, out_xfer=1: skid moves to main and skid_valid=0. No input is accepted because InReady=0.
  - Main full, skid full, out_xfer=0: everything holds.
- Main is never empty while skid is full.
- Words leave the stage in the order they arrived. No word is duplicated or lost except by Flush.
- Stall=1 behaves exactly like OutReady=0. It does not force OutValid low.
- HoldCount: increments when OutValid & !out_xfer and saturates at 2^COUNT_WIDTH-1. Flush does not clear it; only reset clears it.

## Timing
- Reset (asynchronous assert, synchronous release): OutValid=0, OutData=FLUSH_VALUE, InReady=1, HoldCount=0, skid_valid=0.
- Latency is 1 cycle: a word accepted at edge N appears on OutData with OutValid=1 after edge N.
- Throughput is 1 word/cycle while out_xfer is continuous.
- InReady falls the cycle after the skid register fills. It rises the cycle after the skid register drains, so there is no combinational path from OutReady or Stall to InReady.
- Up to 2 words can be accepted after the downstream stops; the skid absorbs the second.
- Flush and Stall asserted together: flush wins.
- Flush and InValid asserted together: the word is dropped.
- Reset asserted mid-operation: all contents are discarded immediately, independent of Clk.

## Test plan
- Streaming: OutReady=1, Stall=0, InData=1,2,3,4 on consecutive cycles → OutData=1,2,3,4 one cycle later, OutValid=1 for 4 cycles, HoldCount=0.
- Back-pressure: send 10,11,12 while OutReady=0 from the cycle word 10 appears → OutValid=1 with OutData=10, InReady=0 after 11 is captured, 12 held upstream. Then OutReady=1 → outputs 10,11,12 in order. HoldCount equals the number of hold cycles.
- Stall: main=0x55, Stall=1 for 3 cycles with OutReady=1 → OutData stays 0x55, OutValid=1, HoldCount +3. After release, 0x55 transfers once.
- Flush with full skid: main=A and skid=B, Flush=1 with InValid=1 and InData=C → next cycle OutValid=0, OutData=0, InReady=1. A, B and C never appear.
- Reset mid-stream: Reset_n low between clock edges while holding data → outputs take their reset values immediately. After release, a new word 7 emerges 1 cycle after acceptance.
- Saturation: COUNT_WIDTH=4, hold OutReady=0 for 20 cycles with a valid word → HoldCount reaches 15 and stays at 15.

Source files
------------

// File: rtl/pipe_stage_reg_if.sv
// pipe_stage_reg_if
// Bundles the handshake, payload and control signals of one pipeline stage
// boundary.
//   master : drives InValid/InData/OutReady/Stall/Flush and observes the stage.
//            Used by the surrounding pipeline or a testbench.
//   slave  : the stage register itself.
// Clock and reset are kept as plain module ports and are not part of the bundle.
interface pipe_stage_reg_if #(
  parameter int DATA_WIDTH  = 64,
  parameter int COUNT_WIDTH = 16
);
  logic                   InValid;
  logic                   InReady;
  logic [DATA_WIDTH-1:0]  InData;
  logic                   OutValid;
  logic                   OutReady;
  logic [DATA_WIDTH-1:0]  OutData;
  logic                   Stall;
  logic                   Flush;
  logic [COUNT_WIDTH-1:0] HoldCount;

  modport master (
    output InValid, InData, OutReady, Stall, Flush,
    input  InReady, OutValid, OutData, HoldCount
  );

  modport slave (
    input  InValid, InData, OutReady, Stall, Flush,
    output InReady, OutValid, OutData, HoldCount
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
// Reusable inter-stage register with a valid/ready handshake and a two-entry
// skid buffer (main + skid), so any boundary can apply back-pressure without
// losing data.
// Ports:
//   Clk      : clock, all state updates on the rising edge
//   Reset_n  : asynchronous active-low reset
//   bus      : pipe_stage_reg_if.slave
//              InValid/InData/InReady   upstream handshake (InReady registered)
//              OutValid/OutData/OutReady downstream handshake (outputs registered)
//              Stall   hold request, behaves exactly like OutReady=0
//              Flush   synchronous discard of all contents, highest priority
//              HoldCount saturating count of cycles held with OutValid=1
module pipe_stage_reg #(
  parameter int                   DATA_WIDTH  = 64,
  parameter logic [DATA_WIDTH-1:0] FLUSH_VALUE = {DATA_WIDTH{1'b0}},
  parameter int                   COUNT_WIDTH = 16
) (
  input  logic              Clk,
  input  logic              Reset_n,
  pipe_stage_reg_if.slave   bus
);

  localparam logic [COUNT_WIDTH-1:0] L_HOLD_MAX = {COUNT_WIDTH{1'b1}};
  localparam logic [COUNT_WIDTH-1:0] L_HOLD_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  logic                   r_main_valid;
  logic [DATA_WIDTH-1:0]  r_main_data;
  logic                   r_skid_valid;
  logic [DATA_WIDTH-1:0]  r_skid_data;
  logic                   r_in_ready;
  logic [COUNT_WIDTH-1:0] r_hold_count;

  logic                   w_in_xfer;
  logic                   w_out_xfer;
  logic                   w_main_valid_nxt;
  logic [DATA_WIDTH-1:0]  w_main_data_nxt;
  logic                   w_skid_valid_nxt;
  logic [DATA_WIDTH-1:0]  w_skid_data_nxt;
  logic [COUNT_WIDTH-1:0] w_hold_count_nxt;

  assign w_in_xfer  = bus.InValid & r_in_ready;
  assign w_out_xfer = r_main_valid & bus.OutReady & ~bus.Stall;

  // Next-state of main/skid storage from occupancy, handshakes and flush
  always_comb begin
    w_main_valid_nxt = r_main_valid;
    w_main_data_nxt  = r_main_data;
    w_skid_valid_nxt = r_skid_valid;
    w_skid_data_nxt  = r_skid_data;
    if (bus.Flush) begin
      w_main_valid_nxt = 1'b0;
      w_skid_valid_nxt = 1'b0;
      w_main_data_nxt  = FLUSH_VALUE;
    end else begin
      case ({r_main_valid, r_skid_valid})
        2'b00: begin
          if (w_in_xfer) begin
            w_main_valid_nxt = 1'b1;
            w_main_data_nxt  = bus.InData;
          end else begin
            w_main_valid_nxt = 1'b0;
          end
        end
        2'b10: begin
          if (w_out_xfer) begin
            if (w_in_xfer) begin
              w_main_data_nxt = bus.InData;
            end else begin
              // Emptied: data is left as-is so OutData keeps its last word
              w_main_valid_nxt = 1'b0;
            end
          end else begin
            if (w_in_xfer) begin
              w_skid_valid_nxt = 1'b1;
              w_skid_data_nxt  = bus.InData;
            end else begin
              w_skid_valid_nxt = 1'b0;
            end
          end
        end
        2'b11: begin
          // InReady is low here, so only a drain of skid into main can happen
          if (w_out_xfer) begin
            w_main_data_nxt  = r_skid_data;
            w_skid_valid_nxt = 1'b0;
          end else begin
            w_skid_valid_nxt = 1'b1;
          end
        end
        default: begin
          // Skid-only is unreachable; promote the skid word so nothing is stuck
          w_main_valid_nxt = 1'b1;
          w_main_data_nxt  = r_skid_data;
          w_skid_valid_nxt = 1'b0;
        end
      endcase
    end
  end

  // Saturating hold counter, unaffected by flush
  always_comb begin
    w_hold_count_nxt = r_hold_count;
    if (r_main_valid && !w_out_xfer && (r_hold_count != L_HOLD_MAX)) begin
      w_hold_count_nxt = r_hold_count + L_HOLD_ONE;
    end else begin
      w_hold_count_nxt = r_hold_count;
    end
  end

  // State registers; InReady is precomputed so it has no path from OutReady/Stall
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_main_valid <= 1'b0;
      r_main_data  <= FLUSH_VALUE;
      r_skid_valid <= 1'b0;
      r_skid_data  <= {DATA_WIDTH{1'b0}};
      r_in_ready   <= 1'b1;
      r_hold_count <= {COUNT_WIDTH{1'b0}};
    end else begin
      r_main_valid <= w_main_valid_nxt;
      r_main_data  <= w_main_data_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      r_skid_data  <= w_skid_data_nxt;
      r_in_ready   <= ~w_skid_valid_nxt;
      r_hold_count <= w_hold_count_nxt;
    end
  end

  assign bus.InReady   = r_in_ready;
  assign bus.OutValid  = r_main_valid;
  assign bus.OutData   = r_main_data;
  assign bus.HoldCount = r_hold_count;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg
// Directed plus randomized bench for pipe_stage_reg. The reference model is a
// word queue (at most two entries) plus the last word to leave, and a plain
// saturating integer for the hold count. A second instance with a 4-bit
// counter and a non-zero flush value covers saturation.
module tb_pipe_stage_reg;

  localparam int DW   = 64;
  localparam int HMAX = 65535;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  pipe_stage_reg_if #(.DATA_WIDTH(DW), .COUNT_WIDTH(16)) bus ();
  pipe_stage_reg_if #(.DATA_WIDTH(8),  .COUNT_WIDTH(4))  sbus ();

  pipe_stage_reg #(.DATA_WIDTH(DW), .FLUSH_VALUE(64'd0), .COUNT_WIDTH(16)) u_dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .bus     (bus)
  );

  pipe_stage_reg #(.DATA_WIDTH(8), .FLUSH_VALUE(8'hA5), .COUNT_WIDTH(4)) u_sat (
    .Clk     (clk),
    .Reset_n (rst_n),
    .bus     (sbus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_stale;
  int            m_hold;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_main();
    logic [DW-1:0] exp_data;
    exp_data = (mq.size() > 0) ? mq[0] : m_stale;
    chk("OutValid",  {63'd0, bus.OutValid}, {63'd0, (mq.size() > 0)});
    chk("OutData",   bus.OutData, exp_data);
    chk("InReady",   {63'd0, bus.InReady}, {63'd0, (mq.size() < 2)});
    chk("HoldCount", {48'd0, bus.HoldCount}, 64'(m_hold));
  endtask

  // One clock: check current outputs, drive inputs, advance DUT and model
  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic ordy,
                       input logic st, input logic fl);
    logic in_x;
    logic out_x;
    check_main();
    bus.InValid  = v;
    bus.InData   = d;
    bus.OutReady = ordy;
    bus.Stall    = st;
    bus.Flush    = fl;
    in_x  = v && (mq.size() < 2);
    out_x = (mq.size() > 0) && ordy && !st;
    @(posedge clk);
    #1;
    if ((mq.size() > 0) && !out_x && (m_hold < HMAX)) m_hold++;
    if (fl) begin
      mq.delete();
      m_stale = 64'd0;
    end else begin
      if (out_x) m_stale = mq.pop_front();
      if (in_x)  mq.push_back(d);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    mq.delete();
    m_stale = 64'd0;
    m_hold  = 0;
    bus.InValid = 1'b0;  bus.InData = 64'd0; bus.OutReady = 1'b1;
    bus.Stall = 1'b0;    bus.Flush = 1'b0;
    sbus.InValid = 1'b0; sbus.InData = 8'd0; sbus.OutReady = 1'b1;
    sbus.Stall = 1'b0;   sbus.Flush = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // reset values
    chk("rst_valid", {63'd0, bus.OutValid}, 64'd0);
    chk("rst_ready", {63'd0, bus.InReady}, 64'd1);
    check_main();

    // streaming 1..4
    for (int i = 1; i <= 4; i++) cycle(1'b1, 64'(i), 1'b1, 1'b0, 1'b0);
    chk("stream_last", bus.OutData, 64'd4);
    repeat (2) cycle(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);

    // back-pressure 10,11,12
    cycle(1'b1, 64'd10, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 64'd11, 1'b0, 1'b0, 1'b0);
    chk("bp_ready_low", {63'd0, bus.InReady}, 64'd0);
    chk("bp_head", bus.OutData, 64'd10);
    repeat (2) cycle(1'b1, 64'd12, 1'b0, 1'b0, 1'b0);
    repeat (2) cycle(1'b1, 64'd12, 1'b1, 1'b0, 1'b0);
    chk("bp_third", bus.OutData, 64'd12);
    repeat (2) cycle(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);

    // stall with OutReady=1
    cycle(1'b1, 64'h55, 1'b1, 1'b0, 1'b0);
    repeat (3) cycle(1'b0, 64'd0, 1'b1, 1'b1, 1'b0);
    chk("stall_data", bus.OutData, 64'h55);
    repeat (2) cycle(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);

    // flush with main and skid full, plus an input word and a stall
    cycle(1'b1, 64'hA, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 64'hB, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 64'hC, 1'b0, 1'b1, 1'b1);
    chk("flush_valid", {63'd0, bus.OutValid}, 64'd0);
    chk("flush_data", bus.OutData, 64'd0);
    repeat (2) cycle(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);

    // asynchronous reset between edges while holding data
    cycle(1'b1, 64'h99, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 64'h9A, 1'b0, 1'b0, 1'b0);
    bus.InValid = 1'b0;
    bus.OutReady = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    mq.delete();
    m_stale = 64'd0;
    m_hold  = 0;
    chk("arst_valid", {63'd0, bus.OutValid}, 64'd0);
    check_main();
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    cycle(1'b1, 64'd7, 1'b1, 1'b0, 1'b0);
    chk("post_rst_word", bus.OutData, 64'd7);
    cycle(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);

    // randomized traffic against the queue model
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 99) < 60), {$urandom, $urandom},
            1'($urandom_range(0, 99) < 65), 1'($urandom_range(0, 99) < 20),
            1'($urandom_range(0, 99) < 4));
    end
    // drain the main instance so it stays idle during the saturation test
    repeat (3) cycle(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
    check_main();

    // saturation on the 4-bit counter instance
    chk("sat_rst_data", {56'd0, sbus.OutData}, 64'hA5);
    chk("sat_rst_hold", {60'd0, sbus.HoldCount}, 64'd0);
    sbus.InValid = 1'b1;
    sbus.InData = 8'h3C;
    sbus.OutReady = 1'b0;
    @(posedge clk);
    #1;
    sbus.InValid = 1'b0;
    chk("sat_loaded", {56'd0, sbus.OutData}, 64'h3C);
    chk("sat_hold0", {60'd0, sbus.HoldCount}, 64'd0);
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      chk("sat_hold", {60'd0, sbus.HoldCount}, 64'((k < 15) ? k : 15));
    end
    sbus.Flush = 1'b1;
    @(posedge clk);
    #1;
    sbus.Flush = 1'b0;
    chk("sat_flush_hold", {60'd0, sbus.HoldCount}, 64'd15);
    chk("sat_flush_data", {56'd0, sbus.OutData}, 64'hA5);
    chk("sat_flush_valid", {63'd0, sbus.OutValid}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
